barrel_shift_seq: RTL and testbench

//  Sequencer for the 16-bit barrel shifter datapath (barrel_shifter16). Accepts one command

---
 rtl/barrel_shift_seq_if.sv | 37 +++
 rtl/barrel_shift_seq.sv | 126 ++++++++++++
 tb/tb_barrel_shift_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/barrel_shift_seq_if.sv
// Command/shifter bundle for barrel_shift_seq.
// The master side drives the command inputs and the combinational shifter
// result; the slave side (the sequencer) drives the registered shifter
// controls, captured result and status strobes.
interface barrel_shift_seq_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             dir;
  logic             rot;
  logic [SHW-1:0]   last;
  logic [SHW-1:0]   stride;
  logic             loop;
  logic             abort;
  logic             tick;
  logic [WIDTH-1:0] sh_din;
  logic [SHW-1:0]   sh_shamt;
  logic             sh_dir;
  logic             sh_rot;
  logic [WIDTH-1:0] sh_dout;
  logic [WIDTH-1:0] result;
  logic             result_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, din, dir, rot, last, stride, loop, abort, tick, sh_dout,
    input  sh_din, sh_shamt, sh_dir, sh_rot, result, result_vld, busy, done
  );

  modport slave (
    input  start, din, dir, rot, last, stride, loop, abort, tick, sh_dout,
    output sh_din, sh_shamt, sh_dir, sh_rot, result, result_vld, busy, done
  );
endinterface

// File: rtl/barrel_shift_seq.sv
// barrel_shift_seq: sweeps the shift amount of an external combinational
// 16-bit barrel shifter from 0 up to a programmed limit, capturing the
// shifter output on every prescaler tick.
// Optional feature: define BSEQ_LOOP_EN to allow a latched loop request to
// wrap the sweep back to shift amount 0 instead of finishing.
module barrel_shift_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input logic               clk,
  input logic               rst_n,
  barrel_shift_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

  state_t         state;
  state_t         state_nx;
  logic [SHW-1:0] last_r;
  logic [SHW-1:0] stride_r;
  logic [SHW-1:0] step;
  logic [SHW:0]   next_ext;
  logic           at_end;
  logic           capture;
  logic           accept;
  logic           wrap_en;

  // Stride of zero behaves as one so the sweep always advances.
  assign step     = (stride_r == '0) ? {{(SHW-1){1'b0}}, 1'b1} : stride_r;
  // One extra bit so a step past the top of the range cannot wrap around.
  assign next_ext = {1'b0, bus.sh_shamt} + {1'b0, step};
  assign at_end   = (bus.sh_shamt == last_r) || (next_ext > {1'b0, last_r});
  assign capture  = (state == STEP) && bus.tick && !bus.abort;
  assign accept   = (state == IDLE) && bus.start && !bus.abort;

`ifdef BSEQ_LOOP_EN
  logic loop_r;

  assign wrap_en = loop_r;

  // Loop request is sampled together with the rest of the command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_r <= 1'b0;
    end else if (accept) begin
      loop_r <= bus.loop;
    end
  end
`else
  logic unused_loop;

  assign unused_loop = bus.loop;
  assign wrap_en     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode plus busy/done, both pure functions of the state.
  always_comb begin
    state_nx = state;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (accept) state_nx = LOAD;
      end
      LOAD: state_nx = bus.abort ? IDLE : STEP;
      STEP: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else if (bus.tick && at_end && !wrap_en) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Command latch, shift-amount stepping and result capture; abort freezes all of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sh_din     <= {WIDTH{1'b0}};
      bus.sh_shamt   <= '0;
      bus.sh_dir     <= 1'b0;
      bus.sh_rot     <= 1'b0;
      bus.result     <= {WIDTH{1'b0}};
      bus.result_vld <= 1'b0;
      last_r         <= '0;
      stride_r       <= '0;
    end else begin
      bus.result_vld <= 1'b0;
      if (accept) begin
        bus.sh_din <= bus.din;
        bus.sh_dir <= bus.dir;
        bus.sh_rot <= bus.rot;
        last_r     <= bus.last;
        stride_r   <= bus.stride;
      end
      if (state == LOAD && !bus.abort) begin
        bus.sh_shamt <= '0;
      end
      if (capture) begin
        bus.result     <= bus.sh_dout;
        bus.result_vld <= 1'b1;
        if (!at_end) begin
          bus.sh_shamt <= next_ext[SHW-1:0];
        end else if (wrap_en) begin
          bus.sh_shamt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Testbench for barrel_shift_seq with a behavioural stand-in for the
// combinational barrel_shifter16 and a sweep reference model.
module tb_barrel_shift_seq;
  localparam int WIDTH = 16;
  localparam int SHW   = 4;
`ifdef BSEQ_LOOP_EN
  localparam bit LOOP_FEATURE = 1'b1;
`else
  localparam bit LOOP_FEATURE = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  barrel_shift_seq_if #(.WIDTH(WIDTH), .SHW(SHW)) bif ();

  barrel_shift_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the combinational shifter fed by the sequencer.
  logic [2*WIDTH-1:0] dbl;
  always_comb begin
    dbl         = {bif.sh_din, bif.sh_din};
    bif.sh_dout = '0;
    if (!bif.sh_rot) begin
      bif.sh_dout = bif.sh_dir ? (bif.sh_din >> bif.sh_shamt) : (bif.sh_din << bif.sh_shamt);
    end else if (!bif.sh_dir) begin
      dbl         = dbl << bif.sh_shamt;
      bif.sh_dout = dbl[2*WIDTH-1:WIDTH];
    end else begin
      dbl         = dbl >> bif.sh_shamt;
      bif.sh_dout = dbl[WIDTH-1:0];
    end
  end

  // Arithmetic reference for one shift/rotate of x by s.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int s, input bit dr, input bit ro);
    int unsigned v;
    v = 32'(x);
    if (!ro) begin
      if (!dr) v = (v * (2 ** s)) % 65536;
      else     v = v / (2 ** s);
    end else begin
      for (int i = 0; i < s; i++) begin
        if (!dr) v = ((v * 2) % 65536) + (v / 32768);
        else     v = (v / 2) + ((v % 2) * 32768);
      end
    end
    return v[15:0];
  endfunction

  // Expected capture sequence of a whole sweep; returns number of captures.
  function automatic int build_exp(input logic [15:0] d, input bit dr, input bit ro, input int la,
                                   input int st, input bit lp, output logic [15:0] e[32]);
    int s;
    int stp;
    int n;
    s   = 0;
    n   = 0;
    stp = (st == 0) ? 1 : st;
    for (int k = 0; k < 32; k++) e[k] = '0;
    while (n < 32) begin
      e[n] = ref_shift(d, s, dr, ro);
      n++;
      if (s + stp > la) begin
        if (lp && LOOP_FEATURE) s = 0;
        else break;
      end else begin
        s = s + stp;
      end
    end
    return n;
  endfunction

  task automatic start_cmd(input logic [15:0] d, input bit dr, input bit ro, input logic [3:0] la,
                           input logic [3:0] st, input bit lp);
    @(posedge clk);
    #1;
    bif.start = 1'b1; bif.din = d; bif.dir = dr; bif.rot = ro;
    bif.last = la; bif.stride = st; bif.loop = lp;
    @(posedge clk);
    #1;
    bif.start  = 1'b0;
    bif.din    = 16'($urandom);
    bif.dir    = 1'($urandom_range(0, 1));
    bif.rot    = 1'($urandom_range(0, 1));
    bif.last   = 4'($urandom);
    bif.stride = 4'($urandom);
  endtask

  task automatic pulse_tick(output logic vld, output logic [15:0] res, output logic dn, output logic bsy);
    repeat (2) @(posedge clk);
    #1 bif.tick = 1'b1;
    @(posedge clk);
    #1 bif.tick = 1'b0;
    @(negedge clk);
    vld = bif.result_vld; res = bif.result; dn = bif.done; bsy = bif.busy;
  endtask

  task automatic test_reset();
    logic vld, dn, bsy;
    logic [15:0] res;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bif.sh_din, bif.sh_shamt, bif.sh_dir, bif.sh_rot, bif.result, bif.result_vld, bif.busy, bif.done} !== 41'd0) begin
      errors++;
      $display("FAIL reset_outputs got sh_din=%h shamt=%0d result=%h vld=%b busy=%b done=%b required all 0",
               bif.sh_din, bif.sh_shamt, bif.result, bif.result_vld, bif.busy, bif.done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_tick(vld, res, dn, bsy);
    checks++;
    if ({vld, dn, bsy, res} !== {3'b000, 16'h0000}) begin
      errors++;
      $display("FAIL idle_tick got vld=%b done=%b busy=%b result=%h required 0 0 0 0000", vld, dn, bsy, res);
    end
  endtask

  task automatic test_sweep(input string tag, input logic [15:0] d, input bit dr, input bit ro,
                            input int la, input int st, input bit lp, input bit poke);
    logic [15:0] e[32];
    logic [15:0] res;
    logic vld, dn, bsy;
    int n;
    n = build_exp(d, dr, ro, la, st, lp, e);
    start_cmd(d, dr, ro, la[3:0], st[3:0], lp);
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.done} !== 2'b10) begin
      errors++;
      $display("FAIL %s_load got busy=%b done=%b required busy=1 done=0", tag, bif.busy, bif.done);
    end
    @(negedge clk);
    checks++;
    if ({bif.sh_din, bif.sh_dir, bif.sh_rot, bif.sh_shamt} !== {d, dr, ro, 4'd0}) begin
      errors++;
      $display("FAIL %s_first_shamt got din=%h dir=%b rot=%b shamt=%0d required %h %b %b 0",
               tag, bif.sh_din, bif.sh_dir, bif.sh_rot, bif.sh_shamt, d, dr, ro);
    end
    for (int i = 0; i < n; i++) begin
      if (poke && i == 1) begin
        @(posedge clk);
        #1 bif.start = 1'b1; bif.din = 16'($urandom); bif.last = 4'd0;
        @(posedge clk);
        #1 bif.start = 1'b0;
      end
      pulse_tick(vld, res, dn, bsy);
      checks++;
      if ({vld, dn, res} !== {1'b1, (i == n - 1), e[i]}) begin
        errors++;
        $display("FAIL %s_capture%0d got vld=%b done=%b result=%h required vld=1 done=%b result=%h",
                 tag, i, vld, dn, res, (i == n - 1), e[i]);
      end
    end
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.done, bif.result_vld} !== 3'b000) begin
      errors++;
      $display("FAIL %s_end got busy=%b done=%b vld=%b required 0 0 0", tag, bif.busy, bif.done, bif.result_vld);
    end
    pulse_tick(vld, res, dn, bsy);
    checks++;
    if ({vld, dn, bsy, res} !== {3'b000, e[n-1]}) begin
      errors++;
      $display("FAIL %s_after got vld=%b done=%b busy=%b result=%h required 0 0 0 %h", tag, vld, dn, bsy, res, e[n-1]);
    end
  endtask

  task automatic test_abort();
    logic [15:0] res;
    logic vld, dn, bsy;
    start_cmd(16'hA738, 1'b0, 1'b0, 4'd3, 4'd1, 1'b0);
    pulse_tick(vld, res, dn, bsy);
    checks++;
    if ({vld, res} !== {1'b1, 16'hA738}) begin
      errors++;
      $display("FAIL abort_cap0 got vld=%b result=%h required 1 a738", vld, res);
    end
    pulse_tick(vld, res, dn, bsy);
    checks++;
    if ({vld, res} !== {1'b1, 16'h4E70}) begin
      errors++;
      $display("FAIL abort_cap1 got vld=%b result=%h required 1 4e70", vld, res);
    end
    @(posedge clk);
    #1 bif.abort = 1'b1;
    @(posedge clk);
    #1 bif.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.done, bif.result_vld, bif.result, bif.sh_shamt} !== {3'b000, 16'h4E70, 4'd2}) begin
      errors++;
      $display("FAIL abort_idle got busy=%b done=%b vld=%b result=%h shamt=%0d required 0 0 0 4e70 2",
               bif.busy, bif.done, bif.result_vld, bif.result, bif.sh_shamt);
    end
    pulse_tick(vld, res, dn, bsy);
    checks++;
    if ({vld, dn, bsy, res} !== {3'b000, 16'h4E70}) begin
      errors++;
      $display("FAIL abort_after got vld=%b done=%b busy=%b result=%h required 0 0 0 4e70", vld, dn, bsy, res);
    end
    // start together with abort in IDLE must not load
    @(posedge clk);
    #1 bif.start = 1'b1; bif.abort = 1'b1; bif.din = 16'hFFFF;
    @(posedge clk);
    #1 bif.start = 1'b0; bif.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.sh_din} !== {1'b0, 16'hA738}) begin
      errors++;
      $display("FAIL start_abort got busy=%b sh_din=%h required 0 a738", bif.busy, bif.sh_din);
    end
    // tick together with abort in STEP must not capture
    start_cmd(16'h1234, 1'b0, 1'b0, 4'd5, 4'd1, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 bif.tick = 1'b1; bif.abort = 1'b1;
    @(posedge clk);
    #1 bif.tick = 1'b0; bif.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.result_vld, bif.busy, bif.done, bif.result} !== {3'b000, 16'h4E70}) begin
      errors++;
      $display("FAIL tick_abort got vld=%b busy=%b done=%b result=%h required 0 0 0 4e70",
               bif.result_vld, bif.busy, bif.done, bif.result);
    end
    // abort while in LOAD
    start_cmd(16'h5555, 1'b1, 1'b0, 4'd7, 4'd1, 1'b0);
    bif.abort = 1'b1;
    @(posedge clk);
    #1 bif.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.done} !== 2'b00) begin
      errors++;
      $display("FAIL load_abort got busy=%b done=%b required 0 0", bif.busy, bif.done);
    end
  endtask

  task automatic test_busy_start();
    test_sweep("busy_start", 16'h8421, 1'b1, 1'b0, 5, 2, 1'b0, 1'b1);
    test_sweep("last0", 16'hBEEF, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0);
    test_sweep("stride0", 16'h00F1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [15:0] res;
    logic vld, dn, bsy;
    start_cmd(16'hC3A5, 1'b1, 1'b1, 4'd15, 4'd1, 1'b0);
    pulse_tick(vld, res, dn, bsy);
    pulse_tick(vld, res, dn, bsy);
    checks++;
    if ({vld, res} !== {1'b1, ref_shift(16'hC3A5, 1, 1'b1, 1'b1)}) begin
      errors++;
      $display("FAIL arst_pre got vld=%b result=%h required 1 %h", vld, res, ref_shift(16'hC3A5, 1, 1'b1, 1'b1));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.sh_din, bif.sh_shamt, bif.sh_dir, bif.sh_rot, bif.result, bif.result_vld, bif.busy, bif.done} !== 41'd0) begin
      errors++;
      $display("FAIL arst_clear got sh_din=%h shamt=%0d dir=%b rot=%b result=%h busy=%b required all 0",
               bif.sh_din, bif.sh_shamt, bif.sh_dir, bif.sh_rot, bif.result, bif.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_sweep("post_reset", 16'h0F0F, 1'b0, 1'b1, 6, 3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      test_sweep("rand", 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 LOOP_FEATURE ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

`ifdef BSEQ_LOOP_EN
  task automatic test_loop();
    logic [15:0] e[32];
    logic [15:0] res;
    logic vld, dn, bsy;
    int n;
    n = build_exp(16'h0001, 1'b0, 1'b1, 1, 1, 1'b1, e);
    start_cmd(16'h0001, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6 && i < n; i++) begin
      pulse_tick(vld, res, dn, bsy);
      checks++;
      if ({vld, dn, bsy, res} !== {3'b101, e[i]}) begin
        errors++;
        $display("FAIL loop_cap%0d got vld=%b done=%b busy=%b result=%h required 1 0 1 %h", i, vld, dn, bsy, res, e[i]);
      end
    end
    @(posedge clk);
    #1 bif.abort = 1'b1;
    @(posedge clk);
    #1 bif.abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({bif.busy, bif.done} !== 2'b00) begin
      errors++;
      $display("FAIL loop_abort got busy=%b done=%b required 0 0", bif.busy, bif.done);
    end
  endtask
`else
  task automatic test_loop();
    test_sweep("loop_ignored", 16'h0001, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bif.start = 1'b0; bif.din = '0; bif.dir = 1'b0; bif.rot = 1'b0;
    bif.last = '0; bif.stride = '0; bif.loop = 1'b0; bif.abort = 1'b0; bif.tick = 1'b0;
    test_reset();
    test_sweep("shl", 16'hA738, 1'b0, 1'b0, 3, 1, 1'b0, 1'b0);
    test_sweep("rotr", 16'hA738, 1'b1, 1'b1, 15, 4, 1'b0, 1'b0);
    test_abort();
    test_busy_start();
    test_async_reset();
    test_random();
    test_loop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
